// File: rtl/int_ctrl.sv
// Eight-line edge-triggered interrupt controller with a 4-word bus register file
// (PENDING, ENABLE, VECTOR, POLARITY).
module int_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  INT,
   input  logic        CS,
   input  logic [13:0] adresse,
   input  logic        write,
   input  logic [15:0] DataIN,
   output logic [15:0] DataOUT,
   output logic [7:0]  Interrupts
);

   logic [7:0] r_s1, r_s2, r_s3;
   logic [7:0] r_pend, r_en, r_pol;

   logic [7:0] w_edge;
   logic [7:0] w_clr;
   logic [7:0] w_act;
   logic [2:0] w_vec_idx;
   logic       w_wr;
   logic       w_unused;

   // Only the low address bits and the low data byte carry meaning.
   assign w_unused = ^{adresse[13:2], DataIN[15:8]};

   assign w_wr   = CS & write;
   assign w_edge = (r_s2 & ~r_s3 & ~r_pol) | (~r_s2 & r_s3 & r_pol);
   assign w_clr  = (w_wr && (adresse[1:0] == 2'd0)) ? DataIN[7:0] : 8'h00;
   assign w_act  = r_pend & r_en;

   assign Interrupts = w_act;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1   <= 8'h00;
         r_s2   <= 8'h00;
         r_s3   <= 8'h00;
         r_pend <= 8'h00;
         r_en   <= 8'h00;
         r_pol  <= 8'h00;
      end else begin
         r_s1 <= INT;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         // Set is ORed in after the clear so a coincident edge is never lost.
         r_pend <= (r_pend & ~w_clr) | (w_edge & r_en);
         if (w_wr && (adresse[1:0] == 2'd1))
            r_en <= DataIN[7:0];
         if (w_wr && (adresse[1:0] == 2'd3))
            r_pol <= DataIN[7:0];
      end
   end

   always_comb begin
      w_vec_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_act[i])
            w_vec_idx = i[2:0];
      end
   end

   always_comb begin
      DataOUT = 16'h0000;
      if (CS) begin
         case (adresse[1:0])
            2'd0:    DataOUT = {8'h00, r_pend};
            2'd1:    DataOUT = {8'h00, r_en};
            2'd2:    DataOUT = {|w_act, 12'h000, w_vec_idx};
            default: DataOUT = {8'h00, r_pol};
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: bus reads are scored against a queue of
// expected values pushed when each read is issued.
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  INT;
   logic        CS;
   logic [13:0] adresse;
   logic        write;
   logic [15:0] DataIN;
   logic [15:0] DataOUT;
   logic [7:0]  Interrupts;

   int n_cmp = 0;
   int n_mis = 0;
   logic [15:0] sb[$];

   int_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .INT        (INT),
      .CS         (CS),
      .adresse    (adresse),
      .write      (write),
      .DataIN     (DataIN),
      .DataOUT    (DataOUT),
      .Interrupts (Interrupts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      CS = 1'b1; write = 1'b1; adresse = {12'hABC, a}; DataIN = d;
      @(posedge clk);
      #1;
      CS = 1'b0; write = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
      @(negedge clk);
      CS = 1'b1; write = 1'b0; adresse = {12'h123, a};
      sb.push_back(exp);
      #1;
      chk(tag, DataOUT, sb.pop_front());
      CS = 1'b0;
   endtask

   task automatic set_int(input int idx, input logic v);
      @(negedge clk);
      INT[idx] = v;
   endtask

   initial begin
      rst_n = 1'b0; INT = 8'h00; CS = 1'b0; adresse = '0; write = 1'b0; DataIN = '0;
      cycles(2);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("rst_irq", {8'h00, Interrupts}, 16'h0000);
      rd("rst_pend", 2'd0, 16'h0000);
      rd("rst_en",   2'd1, 16'h0000);
      rd("rst_vec",  2'd2, 16'h0000);
      rd("rst_pol",  2'd3, 16'h0000);

      // Single line, latency E2
      wr(2'd1, 16'h0001);
      rd("en_rd", 2'd1, 16'h0001);
      @(negedge clk); INT[0] = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("lat_e1", {8'h00, Interrupts}, 16'h0000);
      @(posedge clk); #1;
      chk("lat_e2", {8'h00, Interrupts}, 16'h0001);
      rd("vec0",  2'd2, 16'h8000);
      rd("pend0", 2'd0, 16'h0001);
      wr(2'd0, 16'h0001);
      rd("w1c0", 2'd0, 16'h0000);

      // Two lines on the same cycle, vector priority and W1C
      wr(2'd1, 16'h00FF);
      @(negedge clk); INT = 8'h25;
      cycles(3);
      rd("pend24", 2'd0, 16'h0024);
      rd("vec2",   2'd2, 16'h8002);
      wr(2'd0, 16'h0004);
      rd("pend20", 2'd0, 16'h0020);
      rd("vec5",   2'd2, 16'h8005);
      chk("irq20", {8'h00, Interrupts}, 16'h0020);
      wr(2'd0, 16'h0020);
      rd("clr20", 2'd0, 16'h0000);

      // Falling-edge polarity on line 3
      wr(2'd3, 16'h0008);
      rd("pol_rd", 2'd3, 16'h0008);
      set_int(3, 1'b1);
      cycles(4);
      rd("pol_rise", 2'd0, 16'h0000);
      @(negedge clk); INT[3] = 1'b0;
      @(posedge clk); @(posedge clk);
      rd("pol_e1", 2'd0, 16'h0000);
      rd("pol_e2", 2'd0, 16'h0008);
      wr(2'd0, 16'h0008);
      wr(2'd3, 16'h0000);
      rd("pol_clr", 2'd0, 16'h0000);

      // Write-1-to-clear coinciding with the setting edge
      set_int(0, 1'b0);
      cycles(3);
      rd("pre_race", 2'd0, 16'h0000);
      @(negedge clk); INT[0] = 1'b1;
      @(posedge clk); @(posedge clk);
      wr(2'd0, 16'h0001);
      rd("race_set", 2'd0, 16'h0001);
      wr(2'd0, 16'h0001);

      // Disabling holds PEND, re-enabling re-exposes it
      set_int(4, 1'b1);
      cycles(3);
      wr(2'd1, 16'h0010);
      rd("pend10", 2'd0, 16'h0010);
      chk("irq10", {8'h00, Interrupts}, 16'h0010);
      wr(2'd1, 16'h0000);
      chk("irq_dis", {8'h00, Interrupts}, 16'h0000);
      rd("pend_held", 2'd0, 16'h0010);
      rd("vec_dis",   2'd2, 16'h0000);
      wr(2'd1, 16'h0010);
      chk("irq_reen", {8'h00, Interrupts}, 16'h0010);
      rd("vec4", 2'd2, 16'h8004);

      // Edge on a disabled line is discarded, not deferred
      set_int(6, 1'b1);
      cycles(3);
      rd("dis_edge", 2'd0, 16'h0010);
      wr(2'd1, 16'h0050);
      chk("no_defer", {8'h00, Interrupts}, 16'h0010);
      wr(2'd2, 16'hFFFF);
      rd("vec_ro", 2'd2, 16'h8004);

      // Reset with all lines high and a simultaneous write
      wr(2'd1, 16'h00FF);
      @(negedge clk);
      INT = 8'hFF; rst_n = 1'b0;
      CS = 1'b1; write = 1'b1; adresse = 14'd1; DataIN = 16'hFFFF;
      @(posedge clk); #1;
      rst_n = 1'b1; CS = 1'b0; write = 1'b0;
      chk("rst2_irq", {8'h00, Interrupts}, 16'h0000);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk($sformatf("rst_hold%0d", k), {8'h00, Interrupts}, 16'h0000);
      end
      rd("rst2_pend", 2'd0, 16'h0000);
      rd("rst2_en",   2'd1, 16'h0000);
      rd("rst2_vec",  2'd2, 16'h0000);
      rd("rst2_pol",  2'd3, 16'h0000);
      @(negedge clk);
      CS = 1'b0; adresse = 14'd1; #1;
      chk("cs0_out", DataOUT, 16'h0000);
      wr(2'd1, 16'h0010);
      @(negedge clk);
      CS = 1'b0; write = 1'b1; adresse = 14'd1; DataIN = 16'h00FF;
      @(posedge clk); #1; write = 1'b0;
      rd("cs0_wr", 2'd1, 16'h0010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
